noc_vc_credit_link: RTL and testbench

- Next-generation NoC link register chain between a router output port and the next router input port.
- Pipelines the forward flit path and the per-VC credit return path by NUM_PIPELINE stages, for NUM_VC virtual channels.
- Adds reset-cleared control bits, so no phantom flits or credits appear after reset.
- Adds per-VC outstanding-credit tracking with sticky protocol-error flags, and optional performance counters.

---
 rtl/noc_vc_credit_link.sv | 210 +++++++++++++++++++++
 tb/tb_noc_vc_credit_link.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_credit_link.sv
// noc_vc_credit_link
//   Register chain between a router output port and the next router input
//   port. The forward flit path and the per-VC credit return path are each
//   delayed by NUM_PIPELINE register stages (0 = combinational pass-through).
//   A per-VC tracker at the upstream boundary counts flits in flight, and it
//   raises sticky protocol-error flags.
//
//   Optional feature macro: NOC_LINK_PERF_EN
//     defined     -> saturating 32-bit flit/packet counters on the downstream side
//     not defined -> perf_flits/perf_packets tied to 0, perf_clr ignored
//
// Ports
//   clk, rst_n                        clock, asynchronous active-low reset
//   data_in/dest_in/user_in/
//   is_tail_in/vc_in/send_in          upstream flit
//   credit_out[NUM_VC]                per-VC credit back to upstream
//   data_out/dest_out/user_out/
//   is_tail_out/vc_out/send_out       downstream flit
//   credit_in[NUM_VC]                 per-VC credit from downstream
//   outstanding[NUM_VC*CNT_W]         per-VC in-flight count, VC v at [v*CNT_W +: CNT_W]
//   err_overflow/err_underflow/err_vc sticky protocol-error flags
//   perf_clr, perf_flits, perf_packets performance counters
module noc_vc_credit_link #(
   parameter int NUM_PIPELINE = 2,
   parameter int NUM_VC       = 2,
   parameter int FLIT_WIDTH   = 128,
   parameter int USER_WIDTH   = 32,
   parameter int DEST_WIDTH   = 8,
   parameter int BUFFER_DEPTH = 4,
   localparam int VC_W        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
   localparam int CNT_W       = $clog2(BUFFER_DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [FLIT_WIDTH-1:0]     data_in,
   input  logic [DEST_WIDTH-1:0]     dest_in,
   input  logic [USER_WIDTH-1:0]     user_in,
   input  logic                      is_tail_in,
   input  logic [VC_W-1:0]           vc_in,
   input  logic                      send_in,
   output logic [NUM_VC-1:0]         credit_out,
   output logic [FLIT_WIDTH-1:0]     data_out,
   output logic [DEST_WIDTH-1:0]     dest_out,
   output logic [USER_WIDTH-1:0]     user_out,
   output logic                      is_tail_out,
   output logic [VC_W-1:0]           vc_out,
   output logic                      send_out,
   input  logic [NUM_VC-1:0]         credit_in,
   output logic [NUM_VC*CNT_W-1:0]   outstanding,
   output logic                      err_overflow,
   output logic                      err_underflow,
   output logic                      err_vc,
   input  logic                      perf_clr,
   output logic [31:0]               perf_flits,
   output logic [31:0]               perf_packets
);

   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(BUFFER_DEPTH);
   localparam logic [VC_W:0]    NUM_VC_EXT = (VC_W + 1)'(NUM_VC);

   genvar gi;

   // ------------------------------------------------------------------
   // Forward and credit pipelines
   // ------------------------------------------------------------------
   generate
      if (NUM_PIPELINE == 0) begin : g_bypass
         assign send_out    = send_in;
         assign vc_out      = vc_in;
         assign data_out    = data_in;
         assign dest_out    = dest_in;
         assign user_out    = user_in;
         assign is_tail_out = is_tail_in;
         assign credit_out  = credit_in;
      end else begin : g_pipe
         logic                  send_reg   [NUM_PIPELINE];
         logic [VC_W-1:0]       vc_reg     [NUM_PIPELINE];
         logic [NUM_VC-1:0]     credit_reg [NUM_PIPELINE];
         logic [FLIT_WIDTH-1:0] data_reg   [NUM_PIPELINE];
         logic [DEST_WIDTH-1:0] dest_reg   [NUM_PIPELINE];
         logic [USER_WIDTH-1:0] user_reg   [NUM_PIPELINE];
         logic                  tail_reg   [NUM_PIPELINE];

         // Control bits are reset so nothing phantom leaves the link after reset.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < NUM_PIPELINE; i++) begin
                  send_reg[i]   <= 1'b0;
                  vc_reg[i]     <= '0;
                  credit_reg[i] <= '0;
               end
            end else begin
               send_reg[0]   <= send_in;
               vc_reg[0]     <= vc_in;
               credit_reg[0] <= credit_in;
               for (int i = 1; i < NUM_PIPELINE; i++) begin
                  send_reg[i]   <= send_reg[i-1];
                  vc_reg[i]     <= vc_reg[i-1];
                  credit_reg[i] <= credit_reg[i-1];
               end
            end
         end

         // Payload carries no reset and no enable so the tools may retime it;
         // it is only meaningful when the matching send bit is set.
         always_ff @(posedge clk) begin
            data_reg[0] <= data_in;
            dest_reg[0] <= dest_in;
            user_reg[0] <= user_in;
            tail_reg[0] <= is_tail_in;
            for (int i = 1; i < NUM_PIPELINE; i++) begin
               data_reg[i] <= data_reg[i-1];
               dest_reg[i] <= dest_reg[i-1];
               user_reg[i] <= user_reg[i-1];
               tail_reg[i] <= tail_reg[i-1];
            end
         end

         assign send_out    = send_reg[NUM_PIPELINE-1];
         assign vc_out      = vc_reg[NUM_PIPELINE-1];
         assign credit_out  = credit_reg[NUM_PIPELINE-1];
         assign data_out    = data_reg[NUM_PIPELINE-1];
         assign dest_out    = dest_reg[NUM_PIPELINE-1];
         assign user_out    = user_reg[NUM_PIPELINE-1];
         assign is_tail_out = tail_reg[NUM_PIPELINE-1];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Per-VC outstanding-credit tracker (upstream side of the link)
   // ------------------------------------------------------------------
   logic [NUM_VC-1:0] inc;
   logic [NUM_VC-1:0] dec;
   logic [NUM_VC-1:0] ovf_hit;
   logic [NUM_VC-1:0] unf_hit;
   logic              vc_bad;

   // An out-of-range VC matches no tracker, so no count moves for it.
   assign vc_bad = send_in && ({1'b0, vc_in} >= NUM_VC_EXT);

   generate
      for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
         logic [CNT_W-1:0] count_reg;

         assign inc[gi] = send_in && (vc_in == VC_W'(gi));
         assign dec[gi] = credit_out[gi];

         // Simultaneous inc and dec cancel; otherwise the count saturates
         // at both ends instead of wrapping.
         assign ovf_hit[gi] = inc[gi] && !dec[gi] && (count_reg == CNT_FULL);
         assign unf_hit[gi] = dec[gi] && !inc[gi] && (count_reg == '0);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               count_reg <= '0;
            end else if (inc[gi] && !dec[gi] && (count_reg != CNT_FULL)) begin
               count_reg <= count_reg + CNT_W'(1);
            end else if (dec[gi] && !inc[gi] && (count_reg != '0)) begin
               count_reg <= count_reg - CNT_W'(1);
            end
         end

         assign outstanding[gi*CNT_W +: CNT_W] = count_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
         err_vc        <= 1'b0;
      end else begin
         if (|ovf_hit) err_overflow  <= 1'b1;
         if (|unf_hit) err_underflow <= 1'b1;
         if (vc_bad)   err_vc        <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------
`ifdef NOC_LINK_PERF_EN
   logic [31:0] perf_flits_reg;
   logic [31:0] perf_packets_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_flits_reg   <= '0;
         perf_packets_reg <= '0;
      end else if (perf_clr) begin
         perf_flits_reg   <= '0;
         perf_packets_reg <= '0;
      end else begin
         if (send_out && (perf_flits_reg != '1))
            perf_flits_reg <= perf_flits_reg + 32'd1;
         if (send_out && is_tail_out && (perf_packets_reg != '1))
            perf_packets_reg <= perf_packets_reg + 32'd1;
      end
   end

   assign perf_flits   = perf_flits_reg;
   assign perf_packets = perf_packets_reg;
`else
   logic unused_perf_clr;
   assign unused_perf_clr = perf_clr;
   assign perf_flits      = '0;
   assign perf_packets    = '0;
`endif

endmodule

// File: tb/tb_noc_vc_credit_link.sv
// Directed bench for noc_vc_credit_link: a NUM_PIPELINE=2 instance carries
// the main sequence and a NUM_PIPELINE=0 instance on the same inputs checks
// the combinational pass-through.
module tb_noc_vc_credit_link;

   localparam int CNT_W = 3;

`ifdef NOC_LINK_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [127:0]  data_in;
   logic [7:0]    dest_in;
   logic [31:0]   user_in;
   logic          is_tail_in;
   logic          vc_in;
   logic          send_in;
   logic [1:0]    credit_in;
   logic          perf_clr;

   logic [1:0]    credit_out;
   logic [127:0]  data_out;
   logic [7:0]    dest_out;
   logic [31:0]   user_out;
   logic          is_tail_out;
   logic          vc_out;
   logic          send_out;
   logic [5:0]    outstanding;
   logic          err_overflow, err_underflow, err_vc;
   logic [31:0]   perf_flits, perf_packets;

   logic [1:0]    credit_out0;
   logic [127:0]  data_out0;
   logic [7:0]    dest_out0;
   logic [31:0]   user_out0;
   logic          is_tail_out0;
   logic          vc_out0;
   logic          send_out0;
   logic [5:0]    outstanding0;
   logic          err_overflow0, err_underflow0, err_vc0;
   logic [31:0]   perf_flits0, perf_packets0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   noc_vc_credit_link #(.NUM_PIPELINE(2), .NUM_VC(2), .FLIT_WIDTH(128),
                        .USER_WIDTH(32), .DEST_WIDTH(8), .BUFFER_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
      .user_in(user_in), .is_tail_in(is_tail_in), .vc_in(vc_in), .send_in(send_in),
      .credit_out(credit_out), .data_out(data_out), .dest_out(dest_out),
      .user_out(user_out), .is_tail_out(is_tail_out), .vc_out(vc_out),
      .send_out(send_out), .credit_in(credit_in), .outstanding(outstanding),
      .err_overflow(err_overflow), .err_underflow(err_underflow), .err_vc(err_vc),
      .perf_clr(perf_clr), .perf_flits(perf_flits), .perf_packets(perf_packets));

   noc_vc_credit_link #(.NUM_PIPELINE(0), .NUM_VC(2), .FLIT_WIDTH(128),
                        .USER_WIDTH(32), .DEST_WIDTH(8), .BUFFER_DEPTH(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
      .user_in(user_in), .is_tail_in(is_tail_in), .vc_in(vc_in), .send_in(send_in),
      .credit_out(credit_out0), .data_out(data_out0), .dest_out(dest_out0),
      .user_out(user_out0), .is_tail_out(is_tail_out0), .vc_out(vc_out0),
      .send_out(send_out0), .credit_in(credit_in), .outstanding(outstanding0),
      .err_overflow(err_overflow0), .err_underflow(err_underflow0), .err_vc(err_vc0),
      .perf_clr(perf_clr), .perf_flits(perf_flits0), .perf_packets(perf_packets0));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; data_in = '0; dest_in = '0; user_in = '0; is_tail_in = 1'b0;
      vc_in = 1'b0; send_in = 1'b0; credit_in = '0; perf_clr = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_send_out",    send_out, 0);
      check("rst_credit_out",  credit_out, 0);
      check("rst_vc_out",      vc_out, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_errs",        {err_overflow, err_underflow, err_vc}, 0);
      check("rst_perf",        {perf_flits, perf_packets}, 0);
      rst_n = 1'b1;
      tick();

      // Single flit on VC1, then its credit
      send_in = 1'b1; vc_in = 1'b1; data_in = 128'hA5; dest_in = 8'h3C;
      user_in = 32'h1234; is_tail_in = 1'b1;
      #1;
      check("p0_send_out", send_out0, 1);
      check("p0_data_out", data_out0, 128'hA5);
      check("p0_vc_out",   vc_out0, 1);
      tick();                                       // cycle 1
      send_in = 1'b0; is_tail_in = 1'b0; data_in = '0;
      $display("[TB] flit vc1 data a5 sent");
      check("c1_send_out",    send_out, 0);
      check("c1_outstanding", outstanding, 6'b001_000);
      tick();                                       // cycle 2
      check("c2_send_out", send_out, 1);
      check("c2_vc_out",   vc_out, 1);
      check("c2_data_out", data_out, 128'hA5);
      check("c2_dest_out", dest_out, 8'h3C);
      check("c2_tail_out", is_tail_out, 1);
      tick();                                       // cycle 3
      check("c3_send_out", send_out, 0);
      tick(); tick();                               // cycle 5
      credit_in = 2'b10;
      #1;
      check("p0_credit_out", credit_out0, 2'b10);
      tick();                                       // cycle 6
      credit_in = 2'b00;
      $display("[TB] credit vc1 returned");
      check("c6_credit_out", credit_out, 0);
      tick();                                       // cycle 7
      check("c7_credit_out",  credit_out, 2'b10);
      check("c7_outstanding", outstanding, 6'b001_000);
      tick();                                       // cycle 8
      check("c8_outstanding", outstanding, 0);
      check("c8_credit_out",  credit_out, 0);
      check("c8_errs",        {err_overflow, err_underflow, err_vc}, 0);

      // Five back-to-back flits on VC0 without credits
      for (int k = 0; k < 5; k++) begin
         send_in = 1'b1; vc_in = 1'b0; data_in = 128'(16 + k);
         tick();
         $display("[TB] burst flit %0d on vc0", k);
         check("burst_outstanding", outstanding, 6'(k < 4 ? k + 1 : 4));
         check("burst_overflow",    err_overflow, (k == 4) ? 1 : 0);
         if (k >= 1) begin
            check("burst_send_out", send_out, 1);
            check("burst_data_out", data_out, 128'(16 + k - 1));
         end
      end
      send_in = 1'b0;
      tick();
      check("fifth_send_out", send_out, 1);
      check("fifth_data_out", data_out, 128'h14);
      tick();
      check("after_burst_send_out", send_out, 0);

      // Send and credit on VC0 in the same cycle at count 4
      credit_in = 2'b01;                            // c0
      tick(); credit_in = 2'b00;                    // c1
      tick();                                       // c2
      check("same_credit_out", credit_out, 2'b01);
      send_in = 1'b1; vc_in = 1'b0;
      tick(); send_in = 1'b0;                       // c3
      $display("[TB] simultaneous send and credit on vc0");
      check("same_outstanding", outstanding, 6'd4);
      check("same_underflow",   err_underflow, 0);

      // Drain VC0 with four credits
      credit_in = 2'b01;
      repeat (4) tick();                            // c7
      credit_in = 2'b00;
      tick();                                       // c8
      check("drain_c8_outstanding", outstanding, 6'd1);
      tick();                                       // c9
      $display("[TB] vc0 drained");
      check("drain_outstanding", outstanding, 0);
      check("drain_underflow",   err_underflow, 0);

      // Credit with VC0 at zero
      credit_in = 2'b01;
      tick(); credit_in = 2'b00;                    // c10
      check("unf_c10", err_underflow, 0);
      tick();                                       // c11
      check("unf_c11",            err_underflow, 0);
      check("unf_c11_credit_out", credit_out, 2'b01);
      tick();                                       // c12
      $display("[TB] credit on empty vc0");
      check("unf_c12",             err_underflow, 1);
      check("unf_c12_outstanding", outstanding, 0);

      // Reset with two flits in flight
      send_in = 1'b1; vc_in = 1'b1; data_in = 128'h77;   // d0
      tick(); data_in = 128'h78;                          // d1
      #2 rst_n = 1'b0;
      #1;
      check("mrst_send_out",    send_out, 0);
      check("mrst_outstanding", outstanding, 0);
      check("mrst_errs",        {err_overflow, err_underflow, err_vc}, 0);
      tick();                                             // d2
      rst_n = 1'b1; send_in = 1'b0;
      $display("[TB] reset with flits in flight");
      check("mrst_d2_send_out", send_out, 0);
      tick();
      check("mrst_d3_send_out", send_out, 0);
      tick();
      check("mrst_d4_send_out",    send_out, 0);
      check("mrst_d4_outstanding", outstanding, 0);
      check("mrst_d4_credit_out",  credit_out, 0);

      // Performance counters: clear, one 3-flit packet, clear again
      perf_clr = 1'b1;
      tick(); perf_clr = 1'b0;
      check("perf_clr0", {perf_flits, perf_packets}, 0);
      for (int k = 0; k < 3; k++) begin
         send_in = 1'b1; vc_in = 1'b0; data_in = 128'(32 + k); is_tail_in = (k == 2);
         tick();
      end
      send_in = 1'b0; is_tail_in = 1'b0;
      tick(); tick();
      $display("[TB] 3-flit packet delivered");
      check("perf_flits",   perf_flits, PERF ? 32'd3 : 32'd0);
      check("perf_packets", perf_packets, PERF ? 32'd1 : 32'd0);
      check("perf_outstanding", outstanding, 6'd3);
      perf_clr = 1'b1;
      tick(); perf_clr = 1'b0;
      $display("[TB] perf counters cleared");
      check("perf_clr1", {perf_flits, perf_packets}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
